// File: rtl/sstl3_halfdup_bus_ctrl_if.sv
// Bundle of the user-side stream/request signals and the IOBUF pad-side
// signals of the half-duplex SSTL3 bus controller.
// master: the controller itself. slave: whatever sits on the other side
// (user logic plus the IOBUF cells).
interface sstl3_halfdup_bus_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             rx_req;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic [WIDTH-1:0] pad_i;
    logic             pad_t;
    logic [WIDTH-1:0] pad_o;
    logic             busy;
    logic             err;

    modport master (
        input  tx_data,
        input  tx_valid,
        input  rx_req,
        input  pad_o,
        output tx_ready,
        output rx_data,
        output rx_valid,
        output pad_i,
        output pad_t,
        output busy,
        output err
    );

    modport slave (
        output tx_data,
        output tx_valid,
        output rx_req,
        output pad_o,
        input  tx_ready,
        input  rx_data,
        input  rx_valid,
        input  pad_i,
        input  pad_t,
        input  busy,
        input  err
    );
endinterface

// File: rtl/sstl3_halfdup_bus_ctrl.sv
// Half-duplex controller for a WIDTH-bit bidirectional SSTL3 pad bus made of
// per-bit IOBUF cells. Drives the shared I/T pair, captures O, arbitrates
// between a valid/ready TX stream and a level-held RX request (RX wins ties),
// and inserts TURN_CYC tri-state cycles after every burst so the two ends of
// the bus never drive at the same time.
//
// Optional feature: define SSTL3_BUS_CONTENTION_CHK_EN to build the contention
// monitor (sticky ERR when the pad readback differs from the driven word).
// Without the macro ERR is a constant 0 and no compare logic exists.
module sstl3_halfdup_bus_ctrl #(
    parameter int WIDTH    = 8,
    parameter int TURN_CYC = 2   // 1..15
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    sstl3_halfdup_bus_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TX   = 2'd1,
        ST_RX   = 2'd2,
        ST_TURN = 2'd3
    } state_e;

    // Counter is 4 bits wide, which covers the full 1..15 range of TURN_CYC.
    localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);

    state_e           state_q;
    logic [3:0]       turn_cnt_q;
    logic [WIDTH-1:0] pad_i_q;
    logic             pad_t_q;
    logic [WIDTH-1:0] rx_data_q;
    logic             rx_valid_q;

    // Main FSM with registered pad drive and receive capture.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            turn_cnt_q <= 4'd0;
            pad_i_q    <= '0;
            pad_t_q    <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            // A sample pulse lasts exactly one cycle unless renewed below.
            rx_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    pad_t_q    <= 1'b1;
                    turn_cnt_q <= 4'd0;
                    if (bus.rx_req) begin
                        state_q <= ST_RX;
                    end else if (bus.tx_valid) begin
                        state_q <= ST_TX;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_TX: begin
                    // RX_REQ is deliberately not looked at until the burst ends.
                    if (bus.tx_valid) begin
                        pad_i_q <= bus.tx_data;
                        pad_t_q <= 1'b0;
                        state_q <= ST_TX;
                    end else begin
                        pad_t_q    <= 1'b1;
                        turn_cnt_q <= 4'd0;
                        state_q    <= ST_TURN;
                    end
                end
                ST_RX: begin
                    pad_t_q <= 1'b1;
                    if (bus.rx_req) begin
                        rx_data_q  <= bus.pad_o;
                        rx_valid_q <= 1'b1;
                        state_q    <= ST_RX;
                    end else begin
                        turn_cnt_q <= 4'd0;
                        state_q    <= ST_TURN;
                    end
                end
                ST_TURN: begin
                    pad_t_q <= 1'b1;
                    if (turn_cnt_q >= TURN_LAST) begin
                        turn_cnt_q <= 4'd0;
                        state_q    <= ST_IDLE;
                    end else begin
                        turn_cnt_q <= turn_cnt_q + 4'd1;
                        state_q    <= ST_TURN;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a safe, undriven bus.
                    pad_t_q    <= 1'b1;
                    turn_cnt_q <= 4'd0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SSTL3_BUS_CONTENTION_CHK_EN
    // True when the pad readback differs from the word being driven.
    function automatic logic word_differs(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
        return |(a ^ b);
    endfunction

    logic err_q;
    logic err_d;

    // Sticky flag: set on any readback mismatch while the bus is driven.
    always_comb begin
        err_d = err_q;
        if (!pad_t_q && word_differs(bus.pad_o, pad_i_q)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Contention flag register; only reset clears it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.tx_ready = (state_q == ST_TX);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.pad_i    = pad_i_q;
    assign bus.pad_t    = pad_t_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_sstl3_halfdup_bus_ctrl.sv
// Directed, table-driven bench for sstl3_halfdup_bus_ctrl (WIDTH=8, TURN_CYC=2).
// Each table row gives the inputs held across one rising edge and the outputs
// expected just after it. While the bus is driven, PAD_O loops back the word
// the previous row expects on PAD_I, like a healthy pad.
module tb_sstl3_halfdup_bus_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    sstl3_halfdup_bus_ctrl_if #(.WIDTH(8)) bus ();

    sstl3_halfdup_bus_ctrl #(.WIDTH(8), .TURN_CYC(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       tv;
        logic [7:0] td;
        logic       rx;
        logic [7:0] po;
        logic       e_t;
        logic [7:0] e_i;
        logic       ci;
        logic       e_rdy;
        logic       e_busy;
        logic       e_rxv;
        logic [7:0] e_rxd;
        logic       cr;
    } vec_t;

    vec_t tbl[32];
    int   n_vec;

    function automatic vec_t mk(input logic r, input logic tv, input logic [7:0] td,
                                input logic rx, input logic [7:0] po,
                                input logic et, input logic [7:0] ei, input logic ci,
                                input logic erdy, input logic ebusy,
                                input logic erxv, input logic [7:0] erxd, input logic cr);
        vec_t v;
        v.rst_n = r;  v.tv = tv;  v.td = td;  v.rx = rx;  v.po = po;
        v.e_t = et;   v.e_i = ei; v.ci = ci;  v.e_rdy = erdy; v.e_busy = ebusy;
        v.e_rxv = erxv; v.e_rxd = erxd; v.cr = cr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       prev_t;
        logic [7:0] prev_i;
        checks   = 0;
        failures = 0;
        rst_n        = 1'b0;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h00;
        bus.rx_req   = 1'b1;
        bus.pad_o    = 8'h00;

        n_vec = 0;
        //                  rst  tv    td     rx    po      pad_t pad_i  ci    rdy   busy  rxv   rxd    cr
        // 1: reset held 3 cycles with TX_VALID and RX_REQ high
        tbl[n_vec++] = mk(1'b0,1'b1,8'h00,1'b1,8'h00, 1'b1,8'h00,1'b1, 1'b0,1'b0,1'b0,8'h00,1'b1);
        tbl[n_vec++] = mk(1'b0,1'b1,8'h00,1'b1,8'h00, 1'b1,8'h00,1'b1, 1'b0,1'b0,1'b0,8'h00,1'b1);
        tbl[n_vec++] = mk(1'b0,1'b1,8'h00,1'b1,8'h00, 1'b1,8'h00,1'b1, 1'b0,1'b0,1'b0,8'h00,1'b1);
        // 2: single TX of A5
        tbl[n_vec++] = mk(1'b1,1'b1,8'hA5,1'b0,8'h00, 1'b1,8'h00,1'b1, 1'b1,1'b1,1'b0,8'h00,1'b0);
        tbl[n_vec++] = mk(1'b1,1'b1,8'hA5,1'b0,8'h00, 1'b0,8'hA5,1'b1, 1'b1,1'b1,1'b0,8'h00,1'b0);
        tbl[n_vec++] = mk(1'b1,1'b0,8'h00,1'b0,8'h00, 1'b1,8'hA5,1'b1, 1'b0,1'b1,1'b0,8'h00,1'b0);
        tbl[n_vec++] = mk(1'b1,1'b0,8'h00,1'b0,8'h00, 1'b1,8'hA5,1'b1, 1'b0,1'b1,1'b0,8'h00,1'b0);
        tbl[n_vec++] = mk(1'b1,1'b0,8'h00,1'b0,8'h00, 1'b1,8'hA5,1'b1, 1'b0,1'b0,1'b0,8'h00,1'b0);
        // 3: burst 01,02,03
        tbl[n_vec++] = mk(1'b1,1'b1,8'h01,1'b0,8'h00, 1'b1,8'hA5,1'b1, 1'b1,1'b1,1'b0,8'h00,1'b0);
        tbl[n_vec++] = mk(1'b1,1'b1,8'h01,1'b0,8'h00, 1'b0,8'h01,1'b1, 1'b1,1'b1,1'b0,8'h00,1'b0);
        tbl[n_vec++] = mk(1'b1,1'b1,8'h02,1'b0,8'h00, 1'b0,8'h02,1'b1, 1'b1,1'b1,1'b0,8'h00,1'b0);
        tbl[n_vec++] = mk(1'b1,1'b1,8'h03,1'b0,8'h00, 1'b0,8'h03,1'b1, 1'b1,1'b1,1'b0,8'h00,1'b0);
        tbl[n_vec++] = mk(1'b1,1'b0,8'h00,1'b0,8'h00, 1'b1,8'h03,1'b1, 1'b0,1'b1,1'b0,8'h00,1'b0);
        tbl[n_vec++] = mk(1'b1,1'b0,8'h00,1'b0,8'h00, 1'b1,8'h03,1'b1, 1'b0,1'b1,1'b0,8'h00,1'b0);
        tbl[n_vec++] = mk(1'b1,1'b0,8'h00,1'b0,8'h00, 1'b1,8'h03,1'b1, 1'b0,1'b0,1'b0,8'h00,1'b0);
        // 4: RX of 3C, C3, 5A
        tbl[n_vec++] = mk(1'b1,1'b0,8'h00,1'b1,8'h99, 1'b1,8'h03,1'b0, 1'b0,1'b1,1'b0,8'h00,1'b1);
        tbl[n_vec++] = mk(1'b1,1'b0,8'h00,1'b1,8'h3C, 1'b1,8'h03,1'b0, 1'b0,1'b1,1'b1,8'h3C,1'b1);
        tbl[n_vec++] = mk(1'b1,1'b0,8'h00,1'b1,8'hC3, 1'b1,8'h03,1'b0, 1'b0,1'b1,1'b1,8'hC3,1'b1);
        tbl[n_vec++] = mk(1'b1,1'b0,8'h00,1'b1,8'h5A, 1'b1,8'h03,1'b0, 1'b0,1'b1,1'b1,8'h5A,1'b1);
        tbl[n_vec++] = mk(1'b1,1'b0,8'h00,1'b0,8'hFF, 1'b1,8'h03,1'b0, 1'b0,1'b1,1'b0,8'h5A,1'b1);
        tbl[n_vec++] = mk(1'b1,1'b0,8'h00,1'b0,8'hEE, 1'b1,8'h03,1'b0, 1'b0,1'b1,1'b0,8'h5A,1'b1);
        tbl[n_vec++] = mk(1'b1,1'b0,8'h00,1'b0,8'hDD, 1'b1,8'h03,1'b0, 1'b0,1'b0,1'b0,8'h5A,1'b1);
        // 5: TX_VALID and RX_REQ together -> RX first, TX after RX + 2 TURN
        tbl[n_vec++] = mk(1'b1,1'b1,8'h77,1'b1,8'h00, 1'b1,8'h03,1'b0, 1'b0,1'b1,1'b0,8'h5A,1'b1);
        tbl[n_vec++] = mk(1'b1,1'b1,8'h77,1'b1,8'h11, 1'b1,8'h03,1'b0, 1'b0,1'b1,1'b1,8'h11,1'b1);
        tbl[n_vec++] = mk(1'b1,1'b1,8'h77,1'b0,8'h22, 1'b1,8'h03,1'b0, 1'b0,1'b1,1'b0,8'h11,1'b1);
        tbl[n_vec++] = mk(1'b1,1'b1,8'h77,1'b0,8'h22, 1'b1,8'h03,1'b0, 1'b0,1'b1,1'b0,8'h11,1'b1);
        tbl[n_vec++] = mk(1'b1,1'b1,8'h77,1'b0,8'h22, 1'b1,8'h03,1'b0, 1'b0,1'b0,1'b0,8'h11,1'b1);
        tbl[n_vec++] = mk(1'b1,1'b1,8'h77,1'b0,8'h22, 1'b1,8'h03,1'b1, 1'b1,1'b1,1'b0,8'h11,1'b0);
        tbl[n_vec++] = mk(1'b1,1'b1,8'h77,1'b0,8'h22, 1'b0,8'h77,1'b1, 1'b1,1'b1,1'b0,8'h11,1'b0);
        tbl[n_vec++] = mk(1'b1,1'b0,8'h00,1'b0,8'h22, 1'b1,8'h77,1'b1, 1'b0,1'b1,1'b0,8'h11,1'b0);
        tbl[n_vec++] = mk(1'b1,1'b0,8'h00,1'b0,8'h22, 1'b1,8'h77,1'b1, 1'b0,1'b1,1'b0,8'h11,1'b0);
        tbl[n_vec++] = mk(1'b1,1'b0,8'h00,1'b0,8'h22, 1'b1,8'h77,1'b1, 1'b0,1'b0,1'b0,8'h11,1'b0);

        prev_t = 1'b1;
        prev_i = 8'h00;
        for (int k = 0; k < n_vec; k++) begin
            rst_n        = tbl[k].rst_n;
            bus.tx_valid = tbl[k].tv;
            bus.tx_data  = tbl[k].td;
            bus.rx_req   = tbl[k].rx;
            if (prev_t == 1'b0) bus.pad_o = prev_i;
            else                bus.pad_o = tbl[k].po;
            tick();
            check($sformatf("v%0d_pad_t", k),    {31'd0, bus.pad_t},    {31'd0, tbl[k].e_t});
            check($sformatf("v%0d_tx_ready", k), {31'd0, bus.tx_ready}, {31'd0, tbl[k].e_rdy});
            check($sformatf("v%0d_busy", k),     {31'd0, bus.busy},     {31'd0, tbl[k].e_busy});
            check($sformatf("v%0d_rx_valid", k), {31'd0, bus.rx_valid}, {31'd0, tbl[k].e_rxv});
            check($sformatf("v%0d_err", k),      {31'd0, bus.err},      32'd0);
            if (tbl[k].ci) check($sformatf("v%0d_pad_i", k), {24'd0, bus.pad_i}, {24'd0, tbl[k].e_i});
            if (tbl[k].cr) check($sformatf("v%0d_rx_data", k), {24'd0, bus.rx_data}, {24'd0, tbl[k].e_rxd});
            prev_t = tbl[k].e_t;
            prev_i = tbl[k].e_i;
        end

        // 6: reset in the second cycle of a 3-word burst
        bus.rx_req = 1'b0;
        bus.tx_valid = 1'b1; bus.tx_data = 8'h10; bus.pad_o = 8'h00;
        tick();                                   // IDLE -> TX
        tick();                                   // 10 driven
        check("rst_burst_drive_t", {31'd0, bus.pad_t}, 32'd0);
        check("rst_burst_drive_i", {24'd0, bus.pad_i}, 32'h10);
        bus.pad_o = 8'h10;
        rst_n = 1'b0; bus.tx_data = 8'h20;
        tick();
        check("rst_mid_pad_t", {31'd0, bus.pad_t}, 32'd1);
        check("rst_mid_busy",  {31'd0, bus.busy},  32'd0);
        check("rst_mid_pad_i", {24'd0, bus.pad_i}, 32'h00);
        rst_n = 1'b1; bus.tx_valid = 1'b0; bus.tx_data = 8'h30;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rst_after%0d_pad_t", k), {31'd0, bus.pad_t}, 32'd1);
            check($sformatf("rst_after%0d_busy", k),  {31'd0, bus.busy},  32'd0);
        end

        // Contention: drive 00 while the pad reads back FF
        bus.tx_valid = 1'b1; bus.tx_data = 8'h00; bus.pad_o = 8'hFF;
        tick();                                   // IDLE -> TX
        tick();                                   // 00 driven, PAD_T=0
        check("cont_drive_t", {31'd0, bus.pad_t}, 32'd0);
        check("cont_pre_err", {31'd0, bus.err},   32'd0);
        bus.tx_valid = 1'b0;
        tick();                                   // compare edge
`ifdef SSTL3_BUS_CONTENTION_CHK_EN
        check("cont_err_set", {31'd0, bus.err}, 32'd1);
`else
        check("cont_err_off", {31'd0, bus.err}, 32'd0);
`endif
        bus.pad_o = 8'h00;
        for (int k = 0; k < 4; k++) begin
            tick();
`ifdef SSTL3_BUS_CONTENTION_CHK_EN
            check($sformatf("cont_err_sticky%0d", k), {31'd0, bus.err}, 32'd1);
`else
            check($sformatf("cont_err_off%0d", k), {31'd0, bus.err}, 32'd0);
`endif
        end
        rst_n = 1'b0;
        tick();
        check("cont_err_cleared", {31'd0, bus.err}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("final_idle_busy", {31'd0, bus.busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
